// File: rtl/id_issue_queue.sv
// Decoded-instruction FIFO between decoder and issue, with flush, occupancy and a control-flow cap.
// Optional build macro ID_ISSUE_QUEUE_BYPASS_EN adds a zero-latency path when the queue is empty.
module id_issue_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned MAX_CTRL = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [DATA_W-1:0]             in_data_i,
    input  logic                          in_ctrl_flow_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_W-1:0]             out_data_o,
    output logic                          out_ctrl_flow_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic [$clog2(MAX_CTRL+1)-1:0] ctrl_cnt_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned KW = $clog2(MAX_CTRL + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [KW-1:0] MAX_C   = KW'(MAX_CTRL);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic              ctrl_mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count_q;
    logic [KW-1:0]     ctrl_q;

    logic stored;
    logic head_ctrl;
    logic stored_pop;
    logic ctrl_block;
    logic push;
    logic bypass_take;
    logic store;
    logic ctrl_inc;
    logic ctrl_dec;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    // Valid/ready: a transfer happens on a side exactly in the cycle where both valid and ready are high.
    // ctrl_block looks only at a pop of a stored head, which keeps the bypass path free of a comb loop.
    always_comb begin
        stored     = (count_q != '0);
        head_ctrl  = ctrl_mem[rd_ptr];
        stored_pop = stored && out_ready_i;
        ctrl_block = in_ctrl_flow_i && (ctrl_q == MAX_C) && !(stored_pop && head_ctrl);
        in_ready_o = !flush_i && ((count_q != DEPTH_C) || stored_pop) && !ctrl_block;
        push       = in_valid_i && in_ready_o;
    end

`ifdef ID_ISSUE_QUEUE_BYPASS_EN
    logic bypass;

    always_comb begin
        bypass          = !stored && !flush_i;
        out_valid_o     = stored || (bypass && in_valid_i && !ctrl_block);
        out_data_o      = bypass ? in_data_i : data_mem[rd_ptr];
        out_ctrl_flow_o = bypass ? in_ctrl_flow_i : head_ctrl;
        // An entry consumed straight through the bypass is never written.
        bypass_take     = bypass && push && out_ready_i;
    end
`else
    always_comb begin
        out_valid_o     = stored;
        out_data_o      = data_mem[rd_ptr];
        out_ctrl_flow_o = head_ctrl;
        bypass_take     = 1'b0;
    end
`endif

    always_comb begin
        store    = push && !bypass_take;
        ctrl_inc = store && in_ctrl_flow_i;
        ctrl_dec = stored_pop && head_ctrl;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_mem[i] <= '0;
                ctrl_mem[i] <= 1'b0;
            end
        end else if (store) begin
            data_mem[wr_ptr] <= in_data_i;
            ctrl_mem[wr_ptr] <= in_ctrl_flow_i;
        end
    end

    // Flush wins over any push or pop in the same cycle; payload is left as-is.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            ctrl_q  <= '0;
        end else if (flush_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            ctrl_q  <= '0;
        end else begin
            if (stored_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (store) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            case ({store, stored_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            case ({ctrl_inc, ctrl_dec})
                2'b10:   ctrl_q <= ctrl_q + KW'(1);
                2'b01:   ctrl_q <= ctrl_q - KW'(1);
                default: ctrl_q <= ctrl_q;
            endcase
        end
    end

    assign count_o    = count_q;
    assign ctrl_cnt_o = ctrl_q;

    cnt_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= DEPTH_C);
    ctrl_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni) ctrl_q <= MAX_C);
    ctrl_le_cnt_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        int'(ctrl_q) <= int'(count_q));

endmodule
